// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: PC width, sequential step, reset vector
// and the number of PC low bits that must be zero for an aligned fetch.
package mips_pkg;

   localparam int unsigned PC_W         = 32;
   localparam int unsigned STEP_BYTES   = 4;
   localparam logic [31:0] RESET_VEC    = 32'h0000_0000;
   localparam int unsigned ALIGN_BITS   = $clog2(STEP_BYTES);
   localparam int unsigned RAS_ENTRIES  = 8;

endpackage : mips_pkg

// File: rtl/ras_stack.sv
// Circular return-address stack. Push writes slot top+1 and advances top;
// pop reads slot top and retreats it. Pushing while full drops the oldest entry.
module ras_stack
   import mips_pkg::*;
#(
   parameter int unsigned W     = PC_W,
   parameter int unsigned DEPTH = RAS_ENTRIES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top_data,
   output logic         empty,
   output logic         full,
   output logic         overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] top;
   logic [PW-1:0] top_inc;
   logic [CW-1:0] count;
   logic [W-1:0]  mem [DEPTH];

   // DEPTH is a power of two, so pointer arithmetic wraps for free.
   assign top_inc  = top + 1'b1;
   assign top_data = mem[top];
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         top <= top_inc;
         if (full) overflow <= 1'b1;
         else      count    <= count + 1'b1;
      end else if (pop && !empty) begin
         top   <= top - 1'b1;
         count <= count - 1'b1;
      end
   end

   // Entry contents need no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) mem[top_inc] <= push_data;
   end

endmodule : ras_stack

// File: rtl/pc_sequencer.sv
// Registered program counter with stall, redirect and call/return through
// an internal return-address stack; drives the instruction-memory address.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter int unsigned N            = PC_W,
   parameter logic [N-1:0] STEP        = N'(STEP_BYTES),
   parameter logic [N-1:0] RESET_VECTOR = N'(RESET_VEC),
   parameter int unsigned RAS_DEPTH    = RAS_ENTRIES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [N-1:0] redirect_pc,
   input  logic         call,
   input  logic         ret,
   output logic [N-1:0] pc,
   output logic [N-1:0] pc_plus,
   output logic         ras_empty,
   output logic         ras_full,
   output logic         ras_overflow,
   output logic         ret_miss,
   output logic         misalign
);

   // Request semantics: there is no back-pressure. Any request present while
   // stall=0 is accepted on that rising edge; stall=1 drops every request.
   localparam logic [N-1:0] ALIGN_MASK = STEP - 1'b1;

   logic [N-1:0] pc_next;
   logic [N-1:0] ras_top;
   logic         ras_push;
   logic         ras_pop;
   logic         ret_miss_next;
   logic         misalign_next;

   assign pc_plus = pc + STEP;

   always_comb begin
      pc_next       = pc_plus;
      ras_push      = 1'b0;
      ras_pop       = 1'b0;
      ret_miss_next = 1'b0;
      misalign_next = 1'b0;
      if (stall) begin
         pc_next = pc;
      end else if (ret) begin
         // An empty stack falls back to the register target supplied by jr.
         if (!ras_empty) begin
            pc_next = ras_top;
            ras_pop = 1'b1;
         end else begin
            pc_next       = redirect_pc;
            ret_miss_next = 1'b1;
         end
      end else if (redirect_valid) begin
         pc_next       = redirect_pc & ~ALIGN_MASK;
         misalign_next = |(redirect_pc & ALIGN_MASK);
         ras_push      = call;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_VECTOR;
         ret_miss <= 1'b0;
         misalign <= 1'b0;
      end else begin
         pc       <= pc_next;
         ret_miss <= ret_miss_next;
         misalign <= misalign_next;
      end
   end

   ras_stack #(
      .W     (N),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus),
      .top_data  (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow)
   );

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, call/return, RAS overflow,
// stall, misalignment, PC wrap-around and asynchronous reset.
module tb_pc_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         stall;
   logic         redirect_valid;
   logic [W-1:0] redirect_pc;
   logic         call;
   logic         ret;
   logic [W-1:0] pc;
   logic [W-1:0] pc_plus;
   logic         ras_empty;
   logic         ras_full;
   logic         ras_overflow;
   logic         ret_miss;
   logic         misalign;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] cur_pc;

   pc_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .call           (call),
      .ret            (ret),
      .pc             (pc),
      .pc_plus        (pc_plus),
      .ras_empty      (ras_empty),
      .ras_full       (ras_full),
      .ras_overflow   (ras_overflow),
      .ret_miss       (ret_miss),
      .misalign       (misalign)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; call = 1'b0; ret = 1'b0;
   endtask

   task automatic drive(input logic rv, input logic [W-1:0] tgt, input logic c, input logic r);
      stall = 1'b0; redirect_valid = rv; redirect_pc = tgt; call = c; ret = r;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #12;
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_pc_plus", pc_plus, 32'h4);
      check_eq("rst_empty", W'(ras_empty), 32'h1);
      check_eq("rst_full", W'(ras_full), 32'h0);
      check_eq("rst_ovf", W'(ras_overflow), 32'h0);
      check_eq("rst_flags", W'({ret_miss, misalign}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rel_pc", pc, 32'h0);

      // sequential fetch
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_eq("seq_pc", pc, W'(4 * i));
         check_eq("seq_pc_plus", pc_plus, W'(4 * i + 4));
      end

      // single call / return
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      check_eq("jmp_pc", pc, 32'h100);
      drive(1'b1, 32'h400, 1'b1, 1'b0);
      check_eq("call_pc", pc, 32'h400);
      check_eq("call_empty", W'(ras_empty), 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("ret_pc", pc, 32'h104);
      check_eq("ret_empty", W'(ras_empty), 32'h1);

      // nine nested calls into an eight-entry stack
      cur_pc = 32'h104;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(cur_pc + 32'h4);
         if (exp_q.size() > 8) void'(exp_q.pop_front());
         cur_pc = 32'h1000 + W'(i) * 32'h100;
         drive(1'b1, cur_pc, 1'b1, 1'b0);
         check_eq("nest_pc", pc, cur_pc);
         if (i == 7) begin
            check_eq("full_at_8", W'(ras_full), 32'h1);
            check_eq("no_ovf_at_8", W'(ras_overflow), 32'h0);
         end
      end
      check_eq("ovf_at_9", W'(ras_overflow), 32'h1);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1);
         check_eq("pop_pc", pc, exp_q.pop_back());
         check_eq("pop_no_miss", W'(ret_miss), 32'h0);
      end
      check_eq("drain_empty", W'(ras_empty), 32'h1);
      drive(1'b0, 32'h7770, 1'b0, 1'b1);
      check_eq("miss_pc", pc, 32'h7770);
      check_eq("miss_pulse", W'(ret_miss), 32'h1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("miss_clear", W'(ret_miss), 32'h0);
      check_eq("after_miss_pc", pc, 32'h7774);
      check_eq("ovf_sticky", W'(ras_overflow), 32'h1);

      // stall holds everything and drops requests
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h2002; call = 1'b1; ret = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("stall_pc", pc, 32'h7774);
         check_eq("stall_empty", W'(ras_empty), 32'h1);
         check_eq("stall_flags", W'({ret_miss, misalign}), 32'h0);
      end
      drive(1'b1, 32'h2002, 1'b1, 1'b0);
      check_eq("unstall_pc", pc, 32'h2000);
      check_eq("unstall_misalign", W'(misalign), 32'h1);
      check_eq("unstall_push", W'(ras_empty), 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("once_pc", pc, 32'h2004);
      check_eq("once_misalign", W'(misalign), 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("stall_ret_pc", pc, 32'h7778);

      // misaligned target
      drive(1'b1, 32'h203, 1'b0, 1'b0);
      check_eq("mis_pc", pc, 32'h200);
      check_eq("mis_pulse", W'(misalign), 32'h1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("mis_clear", W'(misalign), 32'h0);
      check_eq("mis_next_pc", pc, 32'h204);

      // wrap-around
      drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      check_eq("wrap_pc_plus", pc_plus, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("wrap_pc", pc, 32'h0);

      // asynchronous reset mid-run
      drive(1'b1, 32'h300, 1'b1, 1'b0);
      check_eq("pre_rst_empty", W'(ras_empty), 32'h0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_pc", pc, 32'h0);
      check_eq("async_rst_empty", W'(ras_empty), 32'h1);
      check_eq("async_rst_ovf", W'(ras_overflow), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_pc", pc, 32'h4);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the MIPS datapath. It replaces the bare combinational PC+1 adder.
- Holds the PC and advances it by a parametrised STEP each cycle.
- Supports stall, branch/jump redirect, and call/return through an internal circular return-address stack (RAS).
- Sits between the hazard/branch logic and the instruction-memory address port.

Parameters:
N, 32, PC width in bits
STEP, 4, sequential increment; must be a power of two, 1..2^(N-1)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be STEP-aligned
RAS_DEPTH, 8, return-address stack entries; power of two, 2..64

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  1 = hold PC and RAS; all other requests ignored
redirect_valid  in  1  branch-taken/jump: load redirect_pc
redirect_pc  in  N  target address
call  in  1  with redirect_valid: jal; push pc_plus onto RAS
ret  in  1  jr $ra: pop RAS top into PC
pc  out  N  current PC (registered)
pc_plus  out  N  pc + STEP (combinational, mod 2^N)
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH
ras_overflow  out  1  sticky: a push occurred while full
ret_miss  out  1  one-cycle pulse: ret accepted with RAS empty
misalign  out  1  one-cycle pulse: accepted redirect_pc not STEP-aligned

Behaviour:
- Async reset (rst_n=0): pc=RESET_VECTOR, RAS count=0, top pointer=0, ras_overflow=0, ret_miss=0, misalign=0. RAS entry contents are don't-care.
- pc_plus = pc + STEP, truncated to N bits. Wrap-around is legal: 32'hFFFF_FFFC -> 0 for N=32, STEP=4.
- One update per rising edge. Latency is 1 cycle from request to new pc.
- Request priority when stall=0:
  1. ret: if RAS non-empty, pc<=RAS[top] and pop (count-1). If empty, pc<=redirect_pc (register fallback) and ret_miss=1 next cycle. call is ignored in this cycle.
  2. redirect_valid: pc<=redirect_pc with low log2(STEP) bits forced to 0. misalign=1 next cycle if those bits were non-zero. If call=1, push pc_plus (the value before the update).
  3. otherwise pc<=pc_plus.
- call without redirect_valid and without ret has no effect. No push occurs.
- ret without redirect_valid on an empty RAS loads redirect_pc regardless.
- stall=1: pc, RAS, count and ras_overflow hold. ret_miss and misalign are 0 the next cycle.
- RAS is circular:
  - push writes slot top+1 (mod RAS_DEPTH); count saturates at RAS_DEPTH.
  - push while full overwrites the oldest entry and sets ras_overflow, which stays set until reset.
  - pop reads slot top then decrements top.
  - After overflow, only the most recent RAS_DEPTH returns are valid.
- ret_miss and misalign are registered pulses. Both are 0 in every cycle not caused by a qualifying event.
- Reset asserted mid-operation clears state immediately (async). The first update happens on the first rising edge after rst_n deasserts.

Decomposition:
- Shared package mips_pkg: PC width constant, STEP_BYTES=4, RESET_VECTOR constant, log2 alignment-bit constant.
- One sub-module: ras_stack. It holds the circular storage, pointer, count, push/pop, full/empty and overflow logic.
- pc_sequencer contains the PC register, adder, priority mux and pulse flags.

Test Plan:
- Reset release, no requests, 4 cycles -> pc = 0, 4, 8, 12, 16. pc_plus always equals pc+4.
- pc=0x100, redirect_valid=1, redirect_pc=0x400, call=1. Next cycle ret=1 -> pc=0x400 then 0x104. ras_empty is 0 after the call and 1 after the return.
- 9 nested calls (RAS_DEPTH=8) from distinct PCs, then 9 rets -> ras_full after the 8th call, ras_overflow=1 after the 9th. The first 8 pops return the latest 8 addresses in LIFO order. The 9th pop gives ret_miss=1 and pc=redirect_pc.
- stall=1 for 3 cycles with redirect_valid=1 and call=1 asserted -> pc and RAS count unchanged, no pulses. After stall drops, the redirect is taken once.
- redirect_pc=0x203 -> pc=0x200, misalign=1 for exactly one cycle.
- N=32, pc=0xFFFF_FFFC with no requests -> pc=0x0000_0000. Assert rst_n=0 mid-run -> pc=RESET_VECTOR immediately and ras_empty=1.
